vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 185 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`timescale 1ns/1ps
// vga_scanout
//   Text-cell VGA scanout for a 640x480 @ 60 Hz display, driven from a 50 MHz
//   clock with a 25 MHz pixel tick. The screen is a grid of 80x60 cells, each
//   8x8 pixels. Every cell is one 16-bit word in memory, and bits [2:0] of that
//   word select one of eight colours. Cell words are prefetched one cell ahead
//   through a read-only memory port.
//
// Ports
//   clk       system clock, 50 MHz
//   reset     asynchronous, active-low reset
//   enable    scanout enable; while low the block idles in a blanked state
//   addr2     memory port-2 read address
//   dataOut2  memory port-2 read data, valid one clk after addr2
//   dataIn2   memory port-2 write data, tied to zero
//   we2       memory port-2 write enable, tied low
//   hsync     horizontal sync, active-low
//   vsync     vertical sync, active-low
//   red/green/blue  pixel colour, zero outside the visible area
//   vblank    high during vertical blanking (framebuffer update window)
module vga_scanout #(
  parameter logic [15:0] FB_BASE = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] addr2,
  input  logic [15:0] dataOut2,
  output logic [15:0] dataIn2,
  output logic        we2,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        vblank
);

  localparam logic [9:0]  H_VISIBLE    = 10'd640;
  localparam logic [9:0]  H_SYNC_FIRST = 10'd656;
  localparam logic [9:0]  H_SYNC_LAST  = 10'd751;
  localparam logic [9:0]  H_LAST_FETCH = 10'd624;
  localparam logic [9:0]  H_ROW_FETCH  = 10'd792;
  localparam logic [9:0]  H_LAST       = 10'd799;
  localparam logic [9:0]  V_VISIBLE    = 10'd480;
  localparam logic [9:0]  V_SYNC_FIRST = 10'd490;
  localparam logic [9:0]  V_SYNC_LAST  = 10'd491;
  localparam logic [9:0]  V_LAST       = 10'd524;
  localparam logic [15:0] ROW_STRIDE   = 16'd80;

  logic        pixTick;
  logic        fetchPending;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [9:0]  nextV;
  logic [15:0] rowBase;
  logic [15:0] nextRowBase;
  logic [2:0]  curCell;
  logic [2:0]  nextCell;
  logic [2:0]  pixelCell;
  logic [23:0] pixelRgb;
  logic        hVisible;
  logic        vVisible;
  logic        cellStart;
  logic        unusedDataBits;

  assign dataIn2 = 16'h0000;
  assign we2     = 1'b0;

  // Only the colour index of a cell word matters.
  assign unusedDataBits = ^dataOut2[15:3];

  assign hVisible  = hcount < H_VISIBLE;
  assign vVisible  = vcount < V_VISIBLE;
  assign cellStart = hcount[2:0] == 3'd0;

  // On the first pixel of a cell, curCell is loaded on the same edge that
  // registers the colour, so the colour must come straight from nextCell.
  assign pixelCell = cellStart ? nextCell : curCell;

  // Line after the current one, and the row base that line will use. The row
  // base steps by one row every 8 display lines instead of multiplying.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nextV       = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    nextRowBase = rowBase;
    if (nextV == 10'd0) begin
      nextRowBase = FB_BASE;
    end else if (nextV < V_VISIBLE && nextV[2:0] == 3'd0) begin
      nextRowBase = rowBase + ROW_STRIDE;
    end
  end

  always_comb begin
    pixelRgb = 24'h000000;
    case (pixelCell)
      3'd1:    pixelRgb = 24'hFF0000;
      3'd2:    pixelRgb = 24'h00FF00;
      3'd3:    pixelRgb = 24'h0000FF;
      3'd4:    pixelRgb = 24'hFFFF00;
      3'd5:    pixelRgb = 24'h00FFFF;
      3'd6:    pixelRgb = 24'hFF00FF;
      3'd7:    pixelRgb = 24'hFFFFFF;
      default: pixelRgb = 24'h000000;
    endcase
  end

  // NOTE: all state uses non-blocking assignments, so every register samples
  // values from before the edge no matter how the statements are ordered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixTick      <= 1'b0;
      // addr2 already points at cell (0,0), so that word is captured on the
      // first clk after release. The first pixel then gets its real colour.
      fetchPending <= 1'b1;
      hcount       <= 10'd0;
      vcount       <= 10'd0;
      rowBase      <= FB_BASE;
      curCell      <= 3'd0;
      nextCell     <= 3'd0;
      addr2        <= FB_BASE;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      red          <= 8'h00;
      green        <= 8'h00;
      blue         <= 8'h00;
      vblank       <= 1'b0;
    end else begin
      pixTick <= ~pixTick;

      // Capture the word addressed on the previous clk.
      if (fetchPending) begin
        nextCell     <= dataOut2[2:0];
        fetchPending <= 1'b0;
      end

      if (pixTick) begin
        if (!enable) begin
          // Idle: blanked outputs, counters parked at the frame origin, and
          // cell (0,0) kept prefetched for the first pixel after re-enable.
          hcount       <= 10'd0;
          vcount       <= 10'd0;
          rowBase      <= FB_BASE;
          addr2        <= FB_BASE;
          fetchPending <= 1'b1;
          hsync        <= 1'b1;
          vsync        <= 1'b1;
          red          <= 8'h00;
          green        <= 8'h00;
          blue         <= 8'h00;
          vblank       <= 1'b1;
        end else begin
          hsync  <= !(hcount >= H_SYNC_FIRST && hcount <= H_SYNC_LAST);
          vsync  <= !(vcount >= V_SYNC_FIRST && vcount <= V_SYNC_LAST);
          vblank <= !vVisible;
          {red, green, blue} <= (hVisible && vVisible) ? pixelRgb : 24'h000000;

          if (cellStart && hVisible && vVisible) begin
            curCell <= nextCell;
          end

          // Prefetch one cell ahead. The last fetch of a line (col 79) is
          // issued at hcount 624, and column 0 of the next row at 792.
          if (vVisible && cellStart && hcount <= H_LAST_FETCH) begin
            addr2        <= rowBase + 16'(hcount[9:3]) + 16'd1;
            fetchPending <= 1'b1;
          end else if (hcount == H_ROW_FETCH && nextV < V_VISIBLE) begin
            addr2        <= nextRowBase;
            fetchPending <= 1'b1;
          end

          if (hcount == H_LAST) begin
            hcount  <= 10'd0;
            vcount  <= nextV;
            rowBase <= nextRowBase;
          end else begin
            hcount <= hcount + 10'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
// Testbench for vga_scanout. It uses a random framebuffer and a pixel-level
// reference model. For each pixel tick, the model computes the expected sync,
// blanking, colour and fetch address from the pixel index since frame start.
module tb_vga_scanout;

  localparam logic [15:0] FB_BASE = 16'h2000;
  localparam int CLK_NS = 20;
  localparam int FB_WORDS = 4800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] addr2;
  logic [15:0] dataOut2;
  logic [15:0] dataIn2;
  logic        we2;
  logic        hsync;
  logic        vsync;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        vblank;

  logic [15:0] fb [FB_WORDS];

  int errors = 0;
  int checks = 0;

  // Model state
  int          pix = 0;
  logic [15:0] expAddr = FB_BASE;
  bit          addrKnown = 1'b0;
  bit          directedFb = 1'b0;

  vga_scanout #(.FB_BASE(FB_BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .addr2   (addr2),
    .dataOut2(dataOut2),
    .dataIn2 (dataIn2),
    .we2     (we2),
    .hsync   (hsync),
    .vsync   (vsync),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .vblank  (vblank)
  );

  always #(CLK_NS / 2) clk = ~clk;

  // Memory: framebuffer words inside the window, address echo elsewhere.
  always_comb begin
    int idx;
    idx = int'(addr2) - int'(FB_BASE);
    if (idx >= 0 && idx < FB_WORDS) dataOut2 = fb[idx];
    else                            dataOut2 = addr2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (pixel %0d)", tag, obs, exp, pix);
    end
  endtask

  function automatic logic [23:0] cellRgb(input logic [15:0] w);
    case (w[2:0])
      3'd0: return 24'h000000;
      3'd1: return 24'hFF0000;
      3'd2: return 24'h00FF00;
      3'd3: return 24'h0000FF;
      3'd4: return 24'hFFFF00;
      3'd5: return 24'h00FFFF;
      3'd6: return 24'hFF00FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic checkResetValues(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, "_vblank"}, 32'(vblank), 32'd0);
    check({tag, "_addr2"}, 32'(addr2), 32'(FB_BASE));
  endtask

  // Advance one pixel tick (two clks), then check the registered outputs.
  // Enable only changes at a negedge, so its present value is the value
  // the DUT sampled on this tick.
  task automatic pixelTick();
    int h;
    int v;
    int nv;
    logic [23:0] expRgb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("we2", 32'(we2), 32'd0);
    check("dataIn2", 32'(dataIn2), 32'd0);
    if (enable) begin
      h = pix % 800;
      v = (pix / 800) % 525;
      expRgb = (h < 640 && v < 480) ? cellRgb(fb[(v / 8) * 80 + h / 8]) : 24'h000000;
      check("hsync", 32'(hsync), 32'(!(h >= 656 && h <= 751)));
      check("vsync", 32'(vsync), 32'(!(v >= 490 && v <= 491)));
      check("vblank", 32'(vblank), 32'(v >= 480));
      check("rgb", 32'({red, green, blue}), 32'(expRgb));
      if (h % 8 == 0 && h <= 624 && v < 480) begin
        expAddr   = 16'(int'(FB_BASE) + (v / 8) * 80 + h / 8 + 1);
        addrKnown = 1'b1;
      end else if (h == 792) begin
        nv = (v + 1) % 525;
        if (nv < 480) begin
          expAddr   = 16'(int'(FB_BASE) + (nv / 8) * 80);
          addrKnown = 1'b1;
        end
      end
      if (addrKnown) check("addr2", 32'(addr2), 32'(expAddr));
      if (directedFb && v < 8 && h < 8) check("cell00_red", 32'({red, green, blue}), 32'h00FF0000);
      if (directedFb && v < 8 && h >= 8 && h < 16) check("cell10_white", 32'({red, green, blue}), 32'h00FFFFFF);
      if (directedFb && v == 0 && h == 624) check("fetch_col79_row0", 32'(addr2), 32'h0000204F);
      if (directedFb && v == 8 && h == 0) check("fetch_col1_row1", 32'(addr2), 32'h00002051);
      pix++;
    end else begin
      check("held_hsync", 32'(hsync), 32'd1);
      check("held_vsync", 32'(vsync), 32'd1);
      check("held_rgb", 32'({red, green, blue}), 32'd0);
      check("held_vblank", 32'(vblank), 32'd1);
      pix       = 0;
      addrKnown = 1'b0;
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset     = 1'b1;
    pix       = 0;
    expAddr   = FB_BASE;
    addrKnown = 1'b1;
  endtask

  task automatic randomizeFb();
    for (int i = 0; i < FB_WORDS; i++) fb[i] = 16'($urandom);
  endtask

  initial begin
    time tRel;
    time tFall1;
    time tFall2;
    time tRise1;
    logic prevH;
    int nRun;

    tFall1 = 0;
    tFall2 = 0;
    tRise1 = 0;
    randomizeFb();
    fb[0] = 16'hFFF9;
    fb[1] = 16'h0007;
    directedFb = 1'b1;

    // Power-on reset with enable already high
    enable = 1'b1;
    #3 reset = 1'b0;
    #2 checkResetValues("por");
    repeat (2) @(negedge clk);
    releaseReset();
    tRel  = $time;
    prevH = hsync;

    // Phase A: run up to hcount 300 of line 18 and measure hsync timing
    for (int n = 0; n < 18 * 800 + 300; n++) begin
      pixelTick();
      if (prevH && !hsync) begin
        if (tFall1 == 0) tFall1 = $time;
        else if (tFall2 == 0) tFall2 = $time;
      end
      if (!prevH && hsync && tFall1 != 0 && tRise1 == 0) tRise1 = $time;
      prevH = hsync;
    end
    check("first_hsync_fall_clk", 32'((tFall1 - tRel) / CLK_NS), 32'd1314);
    check("hsync_low_clk", 32'((tRise1 - tFall1) / CLK_NS), 32'd192);
    check("line_period_clk", 32'((tFall2 - tFall1) / CLK_NS), 32'd1600);
    directedFb = 1'b0;

    // Drop enable at hcount 300; outputs must go to the held state on the next tick
    enable = 1'b0;
    for (int n = 0; n < 40; n++) pixelTick();
    randomizeFb();

    // Phase B: re-enable and restart at (0,0), then drop at a random point
    enable = 1'b1;
    nRun = int'($urandom_range(9600, 6400));
    for (int n = 0; n < nRun; n++) pixelTick();
    enable = 1'b0;
    for (int n = 0; n < 20; n++) pixelTick();

    // Phase C: re-enable, then assert reset asynchronously mid-frame
    enable = 1'b1;
    nRun = int'($urandom_range(4000, 2400));
    for (int n = 0; n < nRun; n++) pixelTick();
    #3 reset = 1'b0;
    #1 checkResetValues("midframe");
    releaseReset();
    for (int n = 0; n < 1700; n++) pixelTick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
